// File: rtl/cmd_frame_assembler.sv
// Receive-side command framer: opcode + NUM_OPERANDS operand words -> one registered frame.
// Optional trailing XOR checksum word is enabled by defining CMD_FRAME_CHECKSUM_EN.
module cmd_frame_assembler #(
    parameter int DATA_W       = 8,
    parameter int NUM_OPERANDS = 2,
    parameter int TIMEOUT_CYC  = 100000
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           rx_data_ready,
    input  logic [DATA_W-1:0]              rx_data,
    output logic                           frame_valid,
    input  logic                           frame_ready,
    output logic [DATA_W-1:0]              frame_op,
    output logic [NUM_OPERANDS*DATA_W-1:0] frame_operands,
    output logic                           busy,
    output logic                           overrun,
    output logic                           timeout_err,
    output logic                           chk_err
);
    localparam int IDX_W = (NUM_OPERANDS > 1) ? $clog2(NUM_OPERANDS) : 1;
    localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_OPERANDS - 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYC);

`ifdef CMD_FRAME_CHECKSUM_EN
    typedef enum logic [1:0] {IDLE, OPND, CHK} state_t;
`else
    typedef enum logic [0:0] {IDLE, OPND} state_t;
`endif

    state_t                                 state_q, state_d;
    logic [IDX_W-1:0]                       idx_q, idx_d;
    logic [CNT_W-1:0]                       cnt_q, cnt_d, cnt_inc;
    logic [DATA_W-1:0]                      op_sh_q, op_sh_d;
    logic [NUM_OPERANDS-1:0][DATA_W-1:0]    opnd_sh_q, opnd_sh_d;
    logic                                   frame_valid_q, frame_valid_d;
    logic [DATA_W-1:0]                      frame_op_q, frame_op_d;
    logic [NUM_OPERANDS-1:0][DATA_W-1:0]    frame_opnd_q, frame_opnd_d;
    logic                                   overrun_q, overrun_d;
    logic                                   timeout_err_q, timeout_err_d;
    logic                                   complete;
`ifdef CMD_FRAME_CHECKSUM_EN
    logic [DATA_W-1:0]                      chk_sum_q, chk_sum_d;
    logic                                   chk_err_q, chk_err_d;
`endif

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        cnt_d         = cnt_q;
        cnt_inc       = cnt_q + 1'b1;
        op_sh_d       = op_sh_q;
        opnd_sh_d     = opnd_sh_q;
        frame_valid_d = frame_valid_q;
        frame_op_d    = frame_op_q;
        frame_opnd_d  = frame_opnd_q;
        overrun_d     = 1'b0;
        timeout_err_d = 1'b0;
        complete      = 1'b0;
`ifdef CMD_FRAME_CHECKSUM_EN
        chk_sum_d     = chk_sum_q;
        chk_err_d     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (rx_data_ready) begin
                    op_sh_d = rx_data;
                    idx_d   = '0;
                    state_d = OPND;
`ifdef CMD_FRAME_CHECKSUM_EN
                    chk_sum_d = rx_data;
`endif
                end
            end
            OPND: begin
                if (rx_data_ready) begin
                    cnt_d            = '0;
                    opnd_sh_d[idx_q] = rx_data;
`ifdef CMD_FRAME_CHECKSUM_EN
                    chk_sum_d = chk_sum_q ^ rx_data;
`endif
                    if (idx_q == LAST_IDX) begin
`ifdef CMD_FRAME_CHECKSUM_EN
                        state_d = CHK;
`else
                        state_d  = IDLE;
                        complete = 1'b1;
`endif
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
`ifdef CMD_FRAME_CHECKSUM_EN
            CHK: begin
                if (rx_data_ready) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    if (rx_data == chk_sum_q) complete  = 1'b1;
                    else                      chk_err_d = 1'b1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        // Idle mid-frame: a strobe on the expiry cycle is handled above and wins.
        if (TIMEOUT_CYC > 0 && state_q != IDLE && !rx_data_ready) begin
            if (cnt_inc == CNT_LIMIT) begin
                timeout_err_d = 1'b1;
                state_d       = IDLE;
                cnt_d         = '0;
            end else begin
                cnt_d = cnt_inc;
            end
        end

        if (frame_valid_q && frame_ready) frame_valid_d = 1'b0;
        if (complete) begin
            if (!frame_valid_q || frame_ready) begin
                frame_valid_d = 1'b1;
                frame_op_d    = op_sh_q;
                frame_opnd_d  = opnd_sh_d;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            cnt_q         <= '0;
            op_sh_q       <= '0;
            opnd_sh_q     <= '0;
            frame_valid_q <= 1'b0;
            frame_op_q    <= '0;
            frame_opnd_q  <= '0;
            overrun_q     <= 1'b0;
            timeout_err_q <= 1'b0;
`ifdef CMD_FRAME_CHECKSUM_EN
            chk_sum_q     <= '0;
            chk_err_q     <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            cnt_q         <= cnt_d;
            op_sh_q       <= op_sh_d;
            opnd_sh_q     <= opnd_sh_d;
            frame_valid_q <= frame_valid_d;
            frame_op_q    <= frame_op_d;
            frame_opnd_q  <= frame_opnd_d;
            overrun_q     <= overrun_d;
            timeout_err_q <= timeout_err_d;
`ifdef CMD_FRAME_CHECKSUM_EN
            chk_sum_q     <= chk_sum_d;
            chk_err_q     <= chk_err_d;
`endif
        end
    end

    assign frame_valid    = frame_valid_q;
    assign frame_op       = frame_op_q;
    assign frame_operands = frame_opnd_q;
    assign busy           = (state_q != IDLE);
    assign overrun        = overrun_q;
    assign timeout_err    = timeout_err_q;
`ifdef CMD_FRAME_CHECKSUM_EN
    assign chk_err        = chk_err_q;
`else
    assign chk_err        = 1'b0;
`endif

endmodule
